// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// rtl/hazard_scoreboard_ctrl_pkg.sv - shared constants and FSM encoding for the hazard scoreboard controller
package hazard_scoreboard_ctrl_pkg;
  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;
endpackage

// File: rtl/sb_counter_bank.sv
// rtl/sb_counter_bank.sv - per-register saturating pending-write counters with pending vector
module sb_counter_bank
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_en,
  input  logic [$clog2(NREG)-1:0] inc_idx,
  input  logic                    dec_en,
  input  logic [$clog2(NREG)-1:0] dec_idx,
  output logic [NREG-1:0]         pend,
  output logic                    ovf
);
  localparam int IDX_W = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             ovf_q;
  logic             ovf_d;

  always_comb begin
    logic inc_hit;
    logic dec_hit;
    ovf_d   = ovf_q;
    inc_hit = 1'b0;
    dec_hit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      inc_hit  = inc_en && (inc_idx == IDX_W'(i));
      dec_hit  = dec_en && (dec_idx == IDX_W'(i));
      // r0 is never tracked; a simultaneous issue and retire on one register cancels out
      if (i != 0 && inc_hit && !dec_hit) begin
        if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (i != 0 && dec_hit && !inc_hit && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) pend[i] = (cnt_q[i] != '0);
  end

  assign ovf = ovf_q;
endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - RAW scoreboard stall and branch flush sequencing between IF/ID and ID/EXE
// Optional HAZARD_FWD_EN: with forwarding present only load destinations are scoreboarded.
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int NREG      = NREG_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FLUSH_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_src1,
  input  logic [4:0]      id_src2,
  input  logic            id_uses_src2,
  input  logic            id_wb_en,
  input  logic [4:0]      id_dest,
  input  logic            id_is_load,
  input  logic            exe_br_taken,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  output logic            freeze,
  output logic            bubble,
  output logic            flush,
  output logic [NREG-1:0] sb_pending,
  output logic            sb_overflow
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       flush_active;
  logic       hz;
  logic       trackable;
  logic       iss;
  logic       ret;
  logic [NREG-1:0] pend;

`ifdef HAZARD_FWD_EN
  assign trackable = id_is_load;
`else
  // every writer is tracked; the load flag only matters when forwarding exists
  logic unused_is_load;
  assign unused_is_load = id_is_load;
  assign trackable = 1'b1;
`endif

  assign hz = id_valid &&
              ((id_src1 != REG_ZERO && pend[id_src1]) ||
               (id_uses_src2 && id_src2 != REG_ZERO && pend[id_src2]));

  assign flush_active = exe_br_taken || (state_q == ST_FLUSH);
  assign freeze       = hz && !flush_active;
  assign bubble       = hz || flush_active;
  assign flush        = flush_active;

  assign iss = id_valid && !hz && !flush_active && id_wb_en && id_dest != REG_ZERO && trackable;
  assign ret = wb_en && wb_dest != REG_ZERO;

  sb_counter_bank #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (iss),
    .inc_idx (id_dest),
    .dec_en  (ret),
    .dec_idx (wb_dest),
    .pend    (pend),
    .ovf     (sb_overflow)
  );

  assign sb_pending = pend;

  // the branch cycle itself is the first flush cycle, so FLUSH lasts FLUSH_CYC-1 cycles
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (exe_br_taken && FLUSH_CYC > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (exe_br_taken) begin
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q <= 2'd1) begin
          state_d = ST_RUN;
          fcnt_d  = 2'd0;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end
endmodule
